// File: rtl/uart_word_tx.sv
// Serialises a WORD_BYTES-wide word as back-to-back 8N1 UART frames, most significant byte first.
// The baud rate is latched when the word is accepted and held until the word has been sent.
//
// state | meaning
// IDLE  | line high, ready for a word (also the done cycle)
// START | start bit (line low) for the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high); then the next byte or IDLE
module uart_word_tx #(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int WORD_BYTES   = 4
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [1:0]              sel_baud,
    input  logic [8*WORD_BYTES-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    tx_data,
    output logic                    tx_status,
    output logic                    done
);
    localparam int W      = 8 * WORD_BYTES;
    localparam int DIV0   = SYS_CLK_FREQ / 4800;
    localparam int DIV1   = SYS_CLK_FREQ / 9600;
    localparam int DIV2   = SYS_CLK_FREQ / 19200;
    localparam int DIV3   = SYS_CLK_FREQ / 38400;
    localparam int CNT_W  = $clog2(DIV0 + 1);
    localparam int BYTE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  div_q, div_nxt;
    logic [CNT_W-1:0]  div_sel;
    logic [2:0]        bit_idx, bit_nxt;
    logic [BYTE_W-1:0] byte_idx, byte_nxt;
    logic [W-1:0]      shreg, shreg_nxt;
    logic [7:0]        cur_byte;
    logic              tx_nxt, done_nxt, tick;

    always_comb begin
        case (sel_baud)
            2'd0:    div_sel = CNT_W'(DIV0);
            2'd1:    div_sel = CNT_W'(DIV1);
            2'd2:    div_sel = CNT_W'(DIV2);
            default: div_sel = CNT_W'(DIV3);
        endcase
    end

    assign cur_byte  = shreg[W-1 -: 8];
    assign tick      = (cnt == '0);
    assign in_ready  = (state == IDLE);
    assign tx_status = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_q;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        shreg_nxt = shreg;
        tx_nxt    = tx_data;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (in_valid) begin
                    state_nxt = START;
                    shreg_nxt = in_data;
                    div_nxt   = div_sel;
                    cnt_nxt   = div_sel - 1'b1;
                    bit_nxt   = '0;
                    byte_nxt  = '0;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    cnt_nxt   = div_q - 1'b1;
                    bit_nxt   = '0;
                    tx_nxt    = cur_byte[0];
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_nxt = div_q - 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_nxt = div_q - 1'b1;
                    if (byte_idx == LAST_BYTE) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        tx_nxt    = 1'b1;
                    end else begin
                        // next start bit follows the stop bit with no idle gap
                        state_nxt = START;
                        byte_nxt  = byte_idx + 1'b1;
                        shreg_nxt = shreg << 8;
                        tx_nxt    = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            tx_data  <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            div_q    <= div_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            shreg    <= shreg_nxt;
            tx_data  <= tx_nxt;
            done     <= done_nxt;
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a scaled clock frequency keeps words short while exercising
// integer truncation of the bit period; the line is compared against a per-cycle frame model.
module tb_uart_word_tx;
    localparam int FREQ = 400_000;
    localparam int WB   = 4;
    localparam int W    = 8 * WB;

    logic         sys_clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   sel_baud = 2'd0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, tx_data, tx_status, done;

    int n_tests = 0;
    int n_fail  = 0;

    uart_word_tx #(.SYS_CLK_FREQ(FREQ), .WORD_BYTES(WB)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .sel_baud (sel_baud),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_status(tx_status),
        .done     (done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] word;
        int           sel;
        int           exp_div;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_div(input int sel);
        return FREQ / (4800 << sel);
    endfunction

    // Line level k cycles after the accepting edge: 10-bit frames, MSB byte first.
    function automatic logic model_tx(input logic [W-1:0] word, input int d, input int k);
        int bp, by, w;
        logic [W-1:0] sh;
        if (k < 1 || k > 40 * d) return 1'b1;
        bp = (k - 1) / d;
        by = bp / 10;
        w  = bp % 10;
        if (w == 0) return 1'b0;
        if (w == 9) return 1'b1;
        sh = word >> (8 * (WB - 1 - by));
        return sh[w - 1];
    endfunction

    task automatic check_idle(input string name);
        chk(name, {60'd0, tx_data, tx_status, in_ready, done}, {60'd0, 4'b1010});
    endtask

    // Offer a word (accepted at the next edge), then follow it to its done cycle or to abort_k.
    task automatic run_word(input logic [W-1:0] word, input int sel, input int d,
                            input int abort_k, input string tag);
        int errs = 0;
        int first = -1;
        int done_k = 0;
        int bp, w, nd;
        logic [W-1:0] rx = '0;
        logic e_tx, e_st;
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        in_data  = word;
        sel_baud = 2'(sel);
        in_valid = 1'b1;
        for (int k = 1; k <= 40 * d + 1; k++) begin
            @(posedge sys_clk);
            #1;
            e_tx = model_tx(word, d, k);
            e_st = (k <= 40 * d);
            if (tx_data !== e_tx || tx_status !== e_st || in_ready !== !e_st ||
                done !== (k == 40 * d + 1)) begin
                errs++;
                if (first < 0) first = k;
            end
            if (done === 1'b1 && done_k == 0) done_k = k;
            bp = (k - 1) / d;
            w  = bp % 10;
            if (e_st && (k - 1) % d == d / 2 && w >= 1 && w <= 8)
                rx[8 * (WB - 1 - bp / 10) + w - 1] = tx_data;
            if (k == abort_k) begin
                if (errs != 0) $display("FAIL %s_prefix first bad cycle %0d", tag, first);
                chk({tag, "_prefix_errs"}, 64'(errs), 64'd0);
                rst = 1'b0;
                in_valid = 1'b0;
                @(posedge sys_clk);
                #1;
                check_idle({tag, "_abort"});
                rst = 1'b1;
                nd = 0;
                for (int j = 0; j < 3 * d; j++) begin
                    @(posedge sys_clk);
                    #1;
                    if (done !== 1'b0 || tx_data !== 1'b1) nd++;
                end
                chk({tag, "_no_done"}, 64'(nd), 64'd0);
                return;
            end
            if (e_st) begin
                // offers while busy must be dropped; baud changes must be ignored
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
                sel_baud = 2'($urandom_range(0, 3));
            end else begin
                in_valid = 1'b0;
            end
        end
        if (errs != 0) $display("FAIL %s_wave first bad cycle %0d", tag, first);
        chk({tag, "_wave_errs"}, 64'(errs), 64'd0);
        chk({tag, "_decode"}, 64'(rx), 64'(word));
        chk({tag, "_done_at"}, 64'(done_k), 64'(40 * d + 1));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0000_0005, 1, 41};
        vecs[1] = '{32'hA5C3_0F81, 3, 10};
        vecs[2] = '{32'hFFFF_FFFF, 2, 20};
        vecs[3] = '{32'h0000_0000, 3, 10};
        vecs[4] = '{32'h8000_0001, 0, 83};

        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge sys_clk);
            #1;
            check_idle("reset_hold");
        end
        in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            #1;
            check_idle("reset_release");
        end

        // consecutive calls are back to back: each accept lands in the previous done cycle
        for (int i = 0; i < 5; i++)
            run_word(vecs[i].word, vecs[i].sel, vecs[i].exp_div, 0, "vec");

        repeat (4) @(posedge sys_clk);
        #1;
        check_idle("gap_idle");

        // abort during bit 3 of the second byte, then a fresh complete word
        run_word(32'h1234_5678, 1, 41, 14 * 41 + 20 + 1, "abort");
        run_word(32'h1234_5678, 1, 41, 0, "after_abort");

        for (int i = 0; i < 6; i++) begin
            int s;
            s = $urandom_range(0, 3);
            run_word($urandom, s, model_div(s), 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter SYS_CLK_FREQ, default 100_000_000, meaning the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter WORD_BYTES, default 4, meaning bytes per transmitted word; W = 8*WORD_BYTES.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port sel_baud, input, 2 bits: baud select, 0:4800, 1:9600, 2:19200, 3:38400.
REQ-006 The block SHALL have port in_data, input, W bits: the word to transmit.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port tx_data, output, 1 bit: serial UART line, idle high.
REQ-010 The block SHALL have port tx_status, output, 1 bit: high while a word transfer is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a word transfer.

Function
REQ-012 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data and sel_baud SHALL be captured on that edge.
REQ-013 Bit period DIV SHALL be computed as SYS_CLK_FREQ / (4800 << sel_baud), integer-truncated, using the sel_baud value captured at accept; sel_baud changes during a transfer SHALL be ignored.
REQ-014 State machine SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on accept.
- START -> DATA after DIV cycles.
- DATA -> STOP after 8*DIV cycles.
- STOP -> START after DIV cycles if bytes remain, else STOP -> IDLE.
REQ-015 Each bit SHALL hold tx_data for exactly DIV sys_clk cycles.
- Line levels: START drives 0, DATA drives bits LSB first, STOP drives 1, IDLE drives 1.
REQ-016 Bytes SHALL be sent most-significant byte first (in_data[W-1:W-8] first, in_data[7:0] last).
- There SHALL be no idle gap between one byte's stop bit and the next byte's start bit.
REQ-017 tx_data SHALL be registered; the start bit SHALL appear on tx_data in cycle N+1 for an accept at edge N.
REQ-018 A full word SHALL occupy exactly WORD_BYTES*10*DIV cycles from the first start-bit cycle to the end of the last stop bit.
REQ-019 in_ready SHALL equal 1 only in IDLE; tx_status SHALL equal 1 in START, DATA and STOP.
REQ-020 done SHALL be high for exactly one cycle: the first IDLE cycle after the final stop bit.
- in_ready SHALL also be 1 in that cycle, and a new accept SHALL be permitted in that same cycle.
REQ-021 in_valid asserted while in_ready=0 SHALL be ignored; the word is neither captured nor queued.
REQ-022 The bit-period counter and bit/byte indices SHALL be wide enough for DIV at 4800 baud with the configured SYS_CLK_FREQ, and SHALL wrap without overflow artefacts.

Reset
REQ-023 While rst=0 at a rising edge, the block SHALL go to IDLE next cycle with outputs tx_data=1, tx_status=0, in_ready=1, done=0.
- All counters and indices SHALL be cleared.
REQ-024 Reset during any state SHALL abort the transfer immediately.
- No done pulse SHALL be produced for the aborted word.
- The line SHALL return high on the next cycle.
REQ-025 An accept SHALL NOT occur on an edge where rst=0.

Verification
REQ-026 Reset: hold rst=0 for 5 cycles then release -> tx_data=1, tx_status=0, in_ready=1, done=0 throughout.
REQ-027 sel_baud=1, 100 MHz, accept 0x00000005 -> DIV=10416; bytes 00,00,00,05 sent back to back.
- Last byte data bits SHALL be 1,0,1,0,0,0,0,0.
- done SHALL pulse exactly 416640 cycles after the first start-bit cycle.
REQ-028 sel_baud=3, accept 0xA5C30F81 -> DIV=2604; a bench receiver SHALL decode A5, C3, 0F, 81 in that order.
- No high gap longer than one stop bit SHALL appear.
REQ-029 in_valid held high with two words queued -> the second word is accepted exactly in the done cycle of the first.
- Words offered while busy SHALL be dropped; tx_status SHALL stay high continuously.
REQ-030 rst=0 during bit 3 of byte 2 -> tx_data=1 next cycle, no done pulse.
- A following accept SHALL transmit a fresh, complete frame.
REQ-031 Toggle sel_baud 1->3 mid-word -> all bits SHALL keep DIV=10416 until IDLE.
- The next word SHALL use DIV=2604.
